// File: rtl/blink_pkg.sv
// rtl/blink_pkg.sv - shared types and constants for the blink scheduler
// Purpose: FSM state type, LED mode encodings and sizing defaults used by
//          blink_scheduler, blink_prescaler and blink_scheduler_if.
// Ports:   none (package).
package blink_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic MODE_TOGGLE   = 1'b0;
   localparam logic MODE_WALK     = 1'b1;

   // Shortest usable tick period; smaller requests are raised to this.
   localparam int   MIN_PERIOD    = 2;

   localparam int   DEFAULT_CNT_W = 26;

endpackage

// File: rtl/blink_scheduler_if.sv
// rtl/blink_scheduler_if.sv - configuration handshake bundle for blink_scheduler
// Purpose: groups the valid/ready configuration offer into one port.
// Ports (members):
//   cfg_valid  - configuration offered by the host
//   cfg_ready  - scheduler accepts the offer when high with cfg_valid
//   cfg_period - tick period in clock cycles
//   cfg_burst  - ticks per run, 0 = free-running
//   cfg_mode   - 0 = toggle all LEDs, 1 = walking single LED
// Modports: master (host side), slave (scheduler side).
interface blink_scheduler_if
   import blink_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_period;
   logic [7:0]       cfg_burst;
   logic             cfg_mode;

   modport master (
      output cfg_valid, cfg_period, cfg_burst, cfg_mode,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_period, cfg_burst, cfg_mode,
      output cfg_ready
   );

endinterface

// File: rtl/blink_prescaler.sv
// rtl/blink_prescaler.sv - period prescaler producing one tick every period cycles
// Purpose: free-running counter that wraps at period-1 and flags the wrap.
// Ports:
//   clock  - system clock
//   reset  - asynchronous active-high reset
//   clr    - synchronous clear, holds the count at zero
//   en     - count enable
//   period - tick period in cycles (>= 2)
//   tick   - high in the cycle whose edge wraps the count to zero
//   count  - current prescaler value
module blink_prescaler
   import blink_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   output logic             tick,
   output logic [CNT_W-1:0] count
);

   assign tick = en && !clr && (count == period - CNT_W'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr || tick) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/blink_scheduler.sv
// rtl/blink_scheduler.sv - IDLE/RUN sequencer for the green LED blink datapath
// Purpose: holds period/burst/mode configuration, runs the prescaler and
//          drives toggle or walking LED patterns with an optional burst limit.
// Ports:
//   clock, reset      - system clock, asynchronous active-high reset
//   cfg               - configuration handshake (blink_scheduler_if.slave)
//   start, stop       - level-sampled run / abort requests (stop wins)
//   led               - LED drive
//   busy              - high while in RUN
//   done              - one-cycle pulse on burst completion
//   tick_count        - registered tick counter (only with BLINK_STATUS_EN)
// Build option: BLINK_STATUS_EN adds the tick_count output.
module blink_scheduler
   import blink_pkg::*;
#(
   parameter int CNT_W          = DEFAULT_CNT_W,
   parameter int DEFAULT_PERIOD = 25000000,
   parameter int NUM_LEDS       = 8
) (
   input  logic                clock,
   input  logic                reset,
   blink_scheduler_if.slave    cfg,
   input  logic                start,
   input  logic                stop,
   output logic [NUM_LEDS-1:0] led,
   output logic                busy,
   output logic                done
`ifdef BLINK_STATUS_EN
   ,
   output logic [7:0]          tick_count
`endif
);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    period_q, period_d;
   logic [7:0]          burst_q, burst_d;
   logic                mode_q, mode_d;
   logic [7:0]          tick_cnt, cnt_d;
   logic [NUM_LEDS-1:0] led_d;
   logic                done_d;
   logic                tick;
   logic [CNT_W-1:0]    pre_count;

   assign cfg.cfg_ready = (state_q == IDLE);

   // Prescaler sits at zero throughout IDLE, so RUN always starts from a clean count.
   blink_prescaler #(
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .clr    (state_q == IDLE),
      .en     (state_q == RUN),
      .period (period_q),
      .tick   (tick),
      .count  (pre_count)
   );

   always_comb begin
      state_d  = state_q;
      period_d = period_q;
      burst_d  = burst_q;
      mode_d   = mode_q;
      cnt_d    = tick_cnt;
      led_d    = led;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg.cfg_valid) begin
               period_d = (cfg.cfg_period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : cfg.cfg_period;
               burst_d  = cfg.cfg_burst;
               mode_d   = cfg.cfg_mode;
            end
            // mode_d already reflects a same-cycle config, so that run uses it.
            if (start && !stop) begin
               state_d = RUN;
               cnt_d   = '0;
               led_d   = (mode_d == MODE_WALK) ? NUM_LEDS'(1) : '0;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               led_d   = '0;
            end else if (tick) begin
               if (burst_q != 8'd0 && tick_cnt == burst_q - 8'd1) begin
                  state_d = IDLE;
                  led_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  led_d = (mode_q == MODE_TOGGLE) ? ~led : {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
                  cnt_d = tick_cnt + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         period_q <= CNT_W'(DEFAULT_PERIOD);
         burst_q  <= '0;
         mode_q   <= MODE_TOGGLE;
         tick_cnt <= '0;
         led      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         burst_q  <= burst_d;
         mode_q   <= mode_d;
         tick_cnt <= cnt_d;
         led      <= led_d;
         busy     <= (state_d == RUN);
         done     <= done_d;
      end
   end

`ifdef BLINK_STATUS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_count <= '0;
      end else begin
         tick_count <= cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_blink_scheduler.sv
// tb/tb_blink_scheduler.sv - scoreboard bench for blink_scheduler
module tb_blink_scheduler;

   localparam int CNT_W    = 26;
   localparam int NUM_LEDS = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop  = 1'b0;
   logic [7:0] led;
   logic       busy;
   logic       done;
`ifdef BLINK_STATUS_EN
   logic [7:0] tick_count;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int          cyc;
      logic [7:0]  led;
      logic        busy;
      logic        done;
      logic [95:0] name;
   } exp_t;

   exp_t       exp_q[$];
   logic       mon_en = 1'b0;
   logic [9:0] prev   = '0;

   blink_scheduler_if #(.CNT_W(CNT_W)) cfg_if ();

   blink_scheduler #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (10),
      .NUM_LEDS       (NUM_LEDS)
   ) dut (
      .clock (clock),
      .reset (reset),
      .cfg   (cfg_if),
      .start (start),
      .stop  (stop),
      .led   (led),
      .busy  (busy),
      .done  (done)
`ifdef BLINK_STATUS_EN
      ,
      .tick_count (tick_count)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: every change of {led,busy,done} must match the next queued expectation.
   always @(negedge clock) begin : monitor
      logic [9:0] obs;
      exp_t       e;
      obs = {led, busy, done};
      if (mon_en && obs !== prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cyc=%0d got led=%h busy=%b done=%b want no change", cyc, led, busy, done);
         end else begin
            e = exp_q.pop_front();
            if (obs !== {e.led, e.busy, e.done} || (e.cyc >= 0 && e.cyc != cyc)) begin
               errors++;
               $display("FAIL %0s got cyc=%0d led=%h busy=%b done=%b want cyc=%0d led=%h busy=%b done=%b",
                        e.name, cyc, led, busy, done, e.cyc, e.led, e.busy, e.done);
            end
         end
      end
      prev = obs;
   end

   task automatic push(input int c, input logic [7:0] l, input logic b, input logic d, input logic [95:0] n);
      exp_t e;
      e.cyc  = c;
      e.led  = l;
      e.busy = b;
      e.done = d;
      e.name = n;
      exp_q.push_back(e);
   endtask

   task automatic chk(input logic [95:0] n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %0s got=%0h want=%0h", n, got, want);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clock);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got pending=%0d want 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clock);
   endtask

   task automatic offer_cfg(input int p, input int b, input logic m);
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_period = CNT_W'(p);
      cfg_if.cfg_burst  = 8'(b);
      cfg_if.cfg_mode   = m;
      chk("cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
   endtask

   initial begin : stimulus
      int         entry;
      logic [7:0] v;
      cfg_if.cfg_valid  = 1'b0;
      cfg_if.cfg_period = '0;
      cfg_if.cfg_burst  = '0;
      cfg_if.cfg_mode   = 1'b0;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
      reset = 1'b0;
      @(negedge clock);
      chk("rel_done", 32'(done), 32'd0);
      mon_en = 1'b1;

      // 1: default period 10, toggle, free-running; reset mid-run
      start = 1'b1;
      entry = cyc + 1;
      push(entry, 8'h00, 1'b1, 1'b0, "t1_entry");
      push(entry + 10, 8'hFF, 1'b1, 1'b0, "t1_tick1");
      @(negedge clock);
      start = 1'b0;
      wait_until(entry + 15);
      push(-1, 8'h00, 1'b0, 1'b0, "t1_reset");
      reset = 1'b1;
      #1;
      chk("t1_rst_led", 32'(led), 32'd0);
      chk("t1_rst_busy", 32'(busy), 32'd0);
      chk("t1_rst_done", 32'(done), 32'd0);
      chk("t1_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      drain(20);

      // 2: period 4, burst 3, toggle
      offer_cfg(4, 3, 1'b0);
      start = 1'b1;
      entry = cyc + 1;
      push(entry, 8'h00, 1'b1, 1'b0, "t2_entry");
      push(entry + 4, 8'hFF, 1'b1, 1'b0, "t2_tick1");
      push(entry + 8, 8'h00, 1'b1, 1'b0, "t2_tick2");
      push(entry + 12, 8'h00, 1'b0, 1'b1, "t2_done");
      push(entry + 13, 8'h00, 1'b0, 1'b0, "t2_done_off");
      @(negedge clock);
      start = 1'b0;
      drain(30);
`ifdef BLINK_STATUS_EN
      chk("t2_tick_count", 32'(tick_count), 32'd2);
`endif

      // 3: walking, period 2, free-running; stop lands on a tick edge
      offer_cfg(2, 0, 1'b1);
      start = 1'b1;
      entry = cyc + 1;
      push(entry, 8'h01, 1'b1, 1'b0, "t3_entry");
      for (int k = 1; k <= 9; k++) begin
         v = 8'h01 << (k % 8);
         push(entry + 2 * k, v, 1'b1, 1'b0, "t3_walk");
      end
      @(negedge clock);
      start = 1'b0;
      wait_until(entry + 19);
`ifdef BLINK_STATUS_EN
      chk("t3_tick_count", 32'(tick_count), 32'd9);
`endif
      stop = 1'b1;
      push(entry + 20, 8'h00, 1'b0, 1'b0, "t3_stop");
      @(negedge clock);
      stop = 1'b0;
      drain(10);

      // 4: period 0 is raised to 2
      offer_cfg(0, 2, 1'b0);
      start = 1'b1;
      entry = cyc + 1;
      push(entry, 8'h00, 1'b1, 1'b0, "t4_entry");
      push(entry + 2, 8'hFF, 1'b1, 1'b0, "t4_tick1");
      push(entry + 4, 8'h00, 1'b0, 1'b1, "t4_done");
      push(entry + 5, 8'h00, 1'b0, 1'b0, "t4_done_off");
      @(negedge clock);
      start = 1'b0;
      drain(15);

      // 5a: config and start in the same cycle
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_period = CNT_W'(3);
      cfg_if.cfg_burst  = 8'd1;
      cfg_if.cfg_mode   = 1'b1;
      start = 1'b1;
      entry = cyc + 1;
      push(entry, 8'h01, 1'b1, 1'b0, "t5a_entry");
      push(entry + 3, 8'h00, 1'b0, 1'b1, "t5a_done");
      push(entry + 4, 8'h00, 1'b0, 1'b0, "t5a_done_off");
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
      start = 1'b0;
      drain(15);

      // 5b: start and stop together in IDLE
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clock);
      start = 1'b0;
      stop  = 1'b0;
      chk("t5b_busy", 32'(busy), 32'd0);
      chk("t5b_ready", 32'(cfg_if.cfg_ready), 32'd1);
      repeat (3) @(negedge clock);

      // 5c: stop on the final tick suppresses done
      offer_cfg(4, 1, 1'b0);
      start = 1'b1;
      entry = cyc + 1;
      push(entry, 8'h00, 1'b1, 1'b0, "t5c_entry");
      @(negedge clock);
      start = 1'b0;
      wait_until(entry + 3);
      stop = 1'b1;
      push(entry + 4, 8'h00, 1'b0, 1'b0, "t5c_stop");
      @(negedge clock);
      stop = 1'b0;
      repeat (3) @(negedge clock);
      drain(5);

      // 6: offer held during RUN is not taken until IDLE
      offer_cfg(5, 0, 1'b0);
      start = 1'b1;
      entry = cyc + 1;
      push(entry, 8'h00, 1'b1, 1'b0, "t6_entry");
      push(entry + 5, 8'hFF, 1'b1, 1'b0, "t6_tick1");
      push(entry + 10, 8'h00, 1'b1, 1'b0, "t6_tick2");
      @(negedge clock);
      start = 1'b0;
      cfg_if.cfg_valid  = 1'b1;
      cfg_if.cfg_period = CNT_W'(2);
      cfg_if.cfg_burst  = 8'd0;
      cfg_if.cfg_mode   = 1'b1;
      @(negedge clock);
      chk("t6_ready_run1", 32'(cfg_if.cfg_ready), 32'd0);
      wait_until(entry + 6);
      chk("t6_ready_run2", 32'(cfg_if.cfg_ready), 32'd0);
      wait_until(entry + 11);
      stop = 1'b1;
      push(entry + 12, 8'h00, 1'b0, 1'b0, "t6_stop");
      @(negedge clock);
      stop = 1'b0;
      chk("t6_ready_idle", 32'(cfg_if.cfg_ready), 32'd1);
      @(negedge clock);
      cfg_if.cfg_valid = 1'b0;
      drain(5);
      start = 1'b1;
      entry = cyc + 1;
      push(entry, 8'h01, 1'b1, 1'b0, "t6_new_entry");
      push(entry + 2, 8'h02, 1'b1, 1'b0, "t6_new_tick");
      @(negedge clock);
      start = 1'b0;
      wait_until(entry + 2);
      stop = 1'b1;
      push(entry + 3, 8'h00, 1'b0, 1'b0, "t6_new_stop");
      @(negedge clock);
      stop = 1'b0;
      drain(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #100000;
      checks++;
      errors++;
      $display("FAIL watchdog got timeout want completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/blink_scheduler.md
Name: blink_scheduler

Overview:
Controller that sequences the counter/LED blink datapath on the board's green LEDs.
- Owns the period prescaler, the blink pattern and an optional burst limit.
- Accepts configuration through a valid/ready handshake and start/stop commands from a host FSM or from keys.
- Sits between control logic and LEDG; replaces a hard-coded count-compare.

Parameters:
CNT_W, 26, prescaler width.
DEFAULT_PERIOD, 25000000, reset period in clock cycles (0.5 s at 50 MHz).
NUM_LEDS, 8, LED output width.

Ports:
clock  in  1  system clock (CLOCK_50 at top level)
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration accepted when high with cfg_valid
cfg_period  in  CNT_W  ticks period in cycles
cfg_burst  in  8  number of ticks per run; 0 = free-running
cfg_mode  in  1  0 = toggle all LEDs, 1 = walking single LED
start  in  1  level-sampled run request
stop  in  1  level-sampled abort request
led  out  NUM_LEDS  LED drive
busy  out  1  high in RUN
done  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE
  - period_q = DEFAULT_PERIOD, burst_q = 0, mode_q = 0
  - prescaler = 0, tick_cnt = 0
  - led = 0, busy = 0, done = 0
  - Reset mid-run aborts immediately; no done pulse is produced.
- States: IDLE, RUN. All outputs are registered.
- cfg_ready = 1 only in IDLE. On cfg_valid && cfg_ready the block captures period_q, burst_q and mode_q on that edge. A cfg_period value below 2 is stored as 2.
- Transitions out of IDLE:
  - IDLE, start=1, stop=0 → RUN on the next edge.
  - On RUN entry: prescaler = 0 and tick_cnt = 0.
  - On RUN entry, led = 0 in toggle mode, or led = 1 (bit 0) in walking mode.
  - busy = 1 from the first cycle in RUN.
- Config and start in the same cycle: the new config is captured and used by that run.
- Stop and start in the same cycle: stop wins and the block stays in IDLE.
- Prescaler in RUN:
  - Increments each cycle.
  - At prescaler == period_q-1 it wraps to 0 and a tick occurs on that edge. The tick period is exactly period_q cycles.
- On a tick that is not the final tick:
  - Toggle mode: led = ~led.
  - Walking mode: led rotates left by 1, bit NUM_LEDS-1 wraps to bit 0.
  - tick_cnt increments (8-bit, wraps at 255 in free-running mode).
- Final tick: burst_q != 0 and tick_cnt == burst_q-1 at the tick. Then:
  - The block goes to IDLE and led = 0.
  - done = 1 for exactly one cycle; busy = 0 on the same edge.
- RUN with stop=1 → IDLE next edge, led = 0, busy = 0, done stays 0. This applies even if the same cycle is a tick.
- start while in RUN is ignored.
- cfg_valid while in RUN is not accepted (cfg_ready = 0) and is held off by the handshake.

Optional Feature:
BLINK_STATUS_EN
- Defined: adds output tick_count [7:0], a registered copy of tick_cnt. It is cleared on reset and on RUN entry, and holds its last value in IDLE.
- Undefined: the port does not exist. Core behaviour is identical.

Decomposition:
Package blink_pkg holds:
- state enum {IDLE, RUN}
- mode constants MODE_TOGGLE = 0, MODE_WALK = 1
- MIN_PERIOD = 2
- default CNT_W

Sub-module blink_prescaler:
- Inputs: clock, reset, clr, en, period.
- Outputs: a tick pulse and the count.
- This is the natural split: the FSM, config registers and LED pattern stay in blink_scheduler.

Test Plan:
1. Reset defaults. Assert reset mid-sim → led = 0, busy = 0, done = 0, cfg_ready = 1 immediately. After release, start gives the first tick 25000000 cycles after RUN entry. The bench may shorten this via parameter override to DEFAULT_PERIOD = 10; the first tick then comes 10 cycles after RUN entry.
2. Config period = 4, burst = 3, toggle mode, then start:
   - busy = 1 next cycle.
   - led 00 → FF at cycle 4 of RUN, FF → 00 at cycle 8.
   - At cycle 12: done = 1 for one cycle, led = 00, busy = 0.
3. Walking mode, period = 2, burst = 0: led sequence 01, 02, 04 … 80, 01 every 2 cycles. It runs indefinitely until stop; stop → led = 0, no done pulse.
4. Config cfg_period = 0 → stored as 2; ticks occur every 2 cycles.
5. Same-cycle cases:
   - Config + start in one cycle → new config used.
   - start + stop in one cycle in IDLE → stays IDLE.
   - stop on a final-tick cycle → IDLE with done = 0.
6. Handshake: cfg_valid held during RUN → cfg_ready = 0 and old config retained. After stop, the offer is accepted on the first IDLE cycle.
